// File: rtl/fetch_buffer.sv
// fetch_buffer: circular instruction queue between fetch/decode and dispatch.
// Accepts up to `N in-order instructions per cycle and presents the oldest
// `N buffered entries to dispatch, lane 0 oldest. Slot storage is never
// cleared; validity follows from the occupancy count alone.

`ifndef N
`define N 4
`endif

module fetch_buffer #(
    parameter int DEPTH      = 16,
    parameter int ENTRY_BITS = 128
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  logic [`N-1:0]                       in_valid,
    input  logic [`N-1:0][ENTRY_BITS-1:0]       in_data,
    output logic                                in_ready,
    output logic [`N-1:0]                       out_valid,
    output logic [`N-1:0][ENTRY_BITS-1:0]       out_data,
    input  logic [$clog2(`N+1)-1:0]             dispatch_count,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int LANES = `N;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pointer wrap relies on natural overflow, so DEPTH must be a power of two.
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * LANES) begin : g_bad_depth
        $error("fetch_buffer: DEPTH must be a power of two and at least 2*N");
    end

    logic [ENTRY_BITS-1:0] r_slots [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic [CNT_W:0]        w_space;
    logic                  w_ready;
    logic                  w_do_enq;
    logic                  w_run;
    logic [CNT_W-1:0]      w_lead_n;
    logic [CNT_W-1:0]      w_enq_n;
    logic [CNT_W-1:0]      w_dispatch;
    logic [CNT_W-1:0]      w_deq_n;

    // Ready only looks at registered occupancy; a same-cycle dequeue never frees room early.
    assign w_space  = (CNT_W + 1)'(DEPTH) - {1'b0, r_count};
    assign w_ready  = (w_space >= (CNT_W + 1)'(LANES));
    assign w_do_enq = w_ready & ~flush;
    assign w_enq_n  = w_do_enq ? w_lead_n : '0;

    // Dispatch may ask for more than is buffered; clamp so pointers stay consistent.
    assign w_dispatch = CNT_W'(dispatch_count);
    assign w_deq_n    = (w_dispatch < r_count) ? w_dispatch : r_count;

    assign in_ready = w_ready;
    assign count    = r_count;

    // Count the unbroken run of valid lanes starting at lane 0; anything after a gap is ignored.
    always_comb begin
        w_lead_n = '0;
        w_run    = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (w_run && in_valid[i]) begin
                w_lead_n = w_lead_n + CNT_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Write accepted lanes into consecutive slots starting at the tail.
    always_ff @(posedge clock) begin
        if (w_do_enq) begin
            for (int i = 0; i < LANES; i++) begin
                if (CNT_W'(i) < w_lead_n) begin
                    r_slots[r_tail + PTR_W'(i)] <= in_data[i];
                end
            end
        end
    end

    // Pointer and occupancy update; flush wins over both enqueue and dequeue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq_n);
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    // Present the oldest entries to dispatch; empty lanes drive zero data.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_count > CNT_W'(i)) begin
                out_valid[i] = 1'b1;
                out_data[i]  = r_slots[r_head + PTR_W'(i)];
            end
        end
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of instruction slots; a power of two and at least 2*`N.
REQ-002 SHALL have parameter ENTRY_BITS, default 128, width of one packed per-instruction decode payload.
REQ-003 SHALL use `N from sys_defs.svh as the lane count; no local override.
REQ-004 SHALL have port: clock  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: flush  in  1  squash all buffered instructions (branch mispredict recovery).
REQ-007 SHALL have port: in_valid  in  [`N]  per-lane valid from fetch/decode.
REQ-008 SHALL have port: in_data  in  [`N][ENTRY_BITS]  per-lane payload, lane 0 oldest.
REQ-009 SHALL have port: in_ready  out  1  buffer can accept a full `N-wide group this cycle.
REQ-010 SHALL have port: out_valid  out  [`N]  per-lane valid toward dispatch, i.e. dispatch's fetch_valid.
REQ-011 SHALL have port: out_data  out  [`N][ENTRY_BITS]  per-lane payload toward dispatch, lane 0 oldest.
REQ-012 SHALL have port: dispatch_count  in  $clog2(`N+1)  instructions dispatch consumed this cycle.
REQ-013 SHALL have port: count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 SHALL be a circular FIFO built from head pointer, tail pointer and occupancy counter, all $clog2-sized, pointers wrapping modulo DEPTH.
REQ-015 SHALL drive in_ready = (DEPTH - count >= `N); the value comes from the registered count only and ignores any same-cycle dequeue.
REQ-016 SHALL compute enq_n as the number of contiguous set in_valid bits starting at lane 0; valid bits after the first clear bit SHALL be ignored.
REQ-017 SHALL, when in_ready=1 and flush=0, write in_data[i] to slot (tail+i) mod DEPTH for i<enq_n and advance tail by enq_n; when in_ready=0 it SHALL write nothing.
REQ-018 SHALL drive out_valid[i] = (count > i) and out_data[i] = slot (head+i) mod DEPTH, combinationally from state; lanes with out_valid[i]=0 SHALL drive out_data[i]='0.
REQ-019 SHALL compute deq_n = min(dispatch_count, count) and advance head by deq_n; a dispatch_count above count SHALL be clamped and SHALL NOT corrupt pointers.
REQ-020 SHALL update count_next = count + enq_n - deq_n when enqueue and dequeue occur in the same cycle; count SHALL never exceed DEPTH or drop below 0.
REQ-021 SHALL make enqueued data visible on out_* one cycle after the accepting edge, with no same-cycle bypass; minimum end-to-end latency is 1 cycle.
REQ-022 SHALL make flush=1 dominant: next state head=tail=count=0, with that cycle's enqueue and dequeue discarded.
REQ-023 SHALL NOT clear slot storage on flush or reset; validity SHALL derive from count alone.

Reset
REQ-024 SHALL, while reset=1 and asynchronously, set head=0, tail=0 and count=0, giving out_valid='0, in_ready=1 and count=0.
REQ-025 SHALL discard any in-flight group on reset assertion mid-operation and SHALL accept input on the first edge after reset deasserts.

Verification
REQ-026 SHALL cover: reset, then in_valid=all-ones for 1 cycle with dispatch_count=0 -> next cycle count=`N, out_valid=all-ones, out_data in lane order.
REQ-027 SHALL cover: in_valid=4'b1011 (N=4) -> only lane 0 and lane 1 enqueued, count=2.
REQ-028 SHALL cover: fill to count=DEPTH-`N+1 -> in_ready=0 and input is dropped; dispatch_count=`N in that same cycle -> count=DEPTH-2*`N+1 next cycle, in_ready=1.
REQ-029 SHALL cover: 3*DEPTH single-instruction enqueues with steady dispatch_count=1 -> in-order data across pointer wrap, count stays at 1.
REQ-030 SHALL cover: count=2, dispatch_count=`N -> count=0 next cycle, head advances by 2 only.
REQ-031 SHALL cover: flush=1 with simultaneous full enqueue and dispatch_count=1 -> next cycle count=0, out_valid='0; reset pulse mid-burst -> immediate out_valid='0.
